fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register feeding the main decoder.
//  Holds the PC and issues one instruction-memory request at a time over a
//  req/ready + rvalid handshake. Presents instr_d/op_d/funct_d to decode.
//  Applies decode stall and branch/jump redirect; at most one fetch outstanding.
// PARAMETERS
//  PC_RESET  32'h0000_0000  PC value loaded on reset (bits [1:0] must be 00)
// PORTS
//  clk                 in   1   system clock; all state updates on rising edge
//  rst_n               in   1   asynchronous, active-low reset
//  stall_d             in   1   decode cannot accept; hold IF/ID contents
//  redirect_valid      in   1   taken branch/jump this cycle; flush and refetch
//  redirect_target     in   32  new PC; bits [1:0] ignored, forced to 00
//  imem_req            out  1   fetch request valid
//  imem_addr           out  32  fetch byte address, always word aligned
//  imem_ready          in   1   memory accepts request this cycle (imem_req & imem_ready)
//  imem_rvalid         in   1   read data valid; one response per accepted request
//  imem_rdata          in   32  fetched instruction word
//  valid_d             out  1   IF/ID holds a live instruction
//  instr_d             out  32  IF/ID instruction; 32'h0 (nop) whenever valid_d=0
//  op_d                out  6   instr_d[31:26], to maindec op
//  funct_d             out  6   instr_d[5:0], to maindec funct
//  pc_d                out  32  PC of instr_d
//  pcplus4_d           out  32  pc_d + 4, modulo 2^32
// BEHAVIOUR
//  Reset (async assert, sync release): pc_f=PC_RESET, state=IDLE, imem_req=0,
//   imem_addr=PC_RESET, valid_d=0, instr_d=0, pc_d=0, pcplus4_d=0, discard=0, buffer empty.
//  State machine, 2-bit state:
//   IDLE: exit on the first clk edge after reset release -> REQ.
//   REQ : imem_req=1, imem_addr=pc_f. On imem_ready -> WAIT.
//   WAIT: imem_req=0. Wait for imem_rvalid.
//         Response with discard=1: drop it, clear discard -> REQ.
//         Response with stall_d=0: load IF/ID (instr, pc_f, pc_f+4), valid_d=1,
//          pc_f+=4 -> REQ.
//         Response with stall_d=1: store it in the 1-entry buffer -> HOLD.
//   HOLD: imem_req=0. When stall_d=0: move the buffer to IF/ID, pc_f+=4 -> REQ.
//  Best-case throughput is one instruction per 2 cycles, from REQ through WAIT
//   (imem_ready=1, rvalid on the next cycle).
//  IF/ID update rules, in priority order:
//   1 redirect_valid: valid_d<=0 and instr_d<=0, even when stall_d=1.
//   2 stall_d: hold all IF/ID outputs.
//   3 new word delivered (WAIT or HOLD as above): load it.
//   4 otherwise: valid_d<=0, instr_d<=0 (bubble).
//  Redirect, highest priority. pc_f<=target&~3 in every state. Then:
//   REQ with imem_ready the same cycle: the request at the old address is
//    accepted; -> WAIT with discard=1.
//   REQ with no imem_ready: stay in REQ; imem_addr shows the target next cycle.
//    Memory must not rely on the address being stable before ready.
//   WAIT: set discard=1, unless rvalid arrives the same cycle, in which case
//    drop that word -> REQ.
//   HOLD: drop the buffer -> REQ.
//   IDLE: -> REQ.
//  Redirect and stall_d together: the flush wins; the next fetch uses the target.
//  PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
//  imem_rvalid outside WAIT is ignored (protocol error, no state change).
//  Reset asserted mid-fetch: the in-flight response is lost; memory must
//   abort or drop it.
//  op_d and funct_d are pure combinational slices of the instr_d register.
// TESTING
//  1 Reset release, imem_ready=1, rvalid one cycle after accept, imem_rdata =
//    8C010004 then 3421000F -> imem_addr 0,4,8; valid_d pulses;
//    op_d=6'b100011 (lw) then 6'b001101 (ori); pc_d=0 then 4.
//  2 stall_d=1 for 5 cycles while a word returns -> goes to HOLD; IF/ID holds;
//    no new imem_req; after release the buffered word appears at pc_d=8.
//  3 redirect_valid with target 32'h0000_0043 while in WAIT -> the old response
//    is discarded (never on instr_d); next imem_addr=32'h0000_0040; valid_d=0
//    for at least one cycle.
//  4 redirect_valid and stall_d both high -> valid_d=0, instr_d=0 next cycle;
//    the refetch starts at the target.
//  5 PC_RESET=32'hFFFF_FFFC -> the second fetch address is 32'h0000_0000;
//    pcplus4_d=0 for the first instruction.
//  6 rst_n low for one cycle while in WAIT -> all outputs at reset values
//    asynchronously; refetch starts at PC_RESET.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request is in flight at a time: imem_req/imem_ready accept it, imem_rvalid returns it.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: PC, single-outstanding
// imem fetch, one-entry stall buffer, and branch/jump redirect with response discard.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_d,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_target,
    fetch_stage_if.master       imem,
    output logic                valid_d,
    output logic [31:0]         instr_d,
    output logic [5:0]          op_d,
    output logic [5:0]          funct_d,
    output logic [31:0]         pc_d,
    output logic [31:0]         pcplus4_d
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc_f;
    logic        r_discard;
    logic [31:0] r_buf;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pcplus4;

    logic [31:0] w_pc_next4;
    logic        w_load;
    logic [31:0] w_load_word;

    assign w_pc_next4  = r_pc_f + 32'd4;
    assign w_load_word = (r_state == S_HOLD) ? r_buf : imem.imem_rdata;
    // A word reaches IF/ID only when neither a flush nor a stall claims this cycle
    assign w_load = !redirect_valid && !stall_d &&
                    (((r_state == S_WAIT) && imem.imem_rvalid && !r_discard) ||
                     (r_state == S_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc_f    <= PC_RESET;
            r_discard <= 1'b0;
            r_buf     <= '0;
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_pc      <= '0;
            r_pcplus4 <= '0;
        end else begin
            if (redirect_valid) begin
                r_valid <= 1'b0;
                r_instr <= '0;
            end else if (stall_d) begin
                r_valid <= r_valid;
            end else if (w_load) begin
                r_valid   <= 1'b1;
                r_instr   <= w_load_word;
                r_pc      <= r_pc_f;
                r_pcplus4 <= w_pc_next4;
            end else begin
                r_valid <= 1'b0;
                r_instr <= '0;
            end

            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (imem.imem_ready) begin
                        r_state   <= S_WAIT;
                        r_discard <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        r_discard <= 1'b0;
                        if (redirect_valid || r_discard) begin
                            r_state <= S_REQ;
                        end else if (stall_d) begin
                            r_buf   <= imem.imem_rdata;
                            r_state <= S_HOLD;
                        end else begin
                            r_pc_f  <= w_pc_next4;
                            r_state <= S_REQ;
                        end
                    end else if (redirect_valid) begin
                        r_discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        r_state <= S_REQ;
                    end else if (!stall_d) begin
                        r_pc_f  <= w_pc_next4;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Placed after the case so a redirect overrides any sequential PC advance
            if (redirect_valid) begin
                r_pc_f <= {redirect_target[31:2], 2'b00};
            end
        end
    end

    assign imem.imem_req  = (r_state == S_REQ);
    assign imem.imem_addr = r_pc_f;

    assign valid_d   = r_valid;
    assign instr_d   = r_instr;
    assign op_d      = r_instr[31:26];
    assign funct_d   = r_instr[5:0];
    assign pc_d      = r_pc;
    assign pcplus4_d = r_pcplus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset check, randomized run
// against a program-order PC model, and a PC wrap check on a second instance.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall_d, redirect_valid;
    logic [31:0] redirect_target;
    logic        valid_d;
    logic [31:0] instr_d, pc_d, pcplus4_d;
    logic [5:0]  op_d, funct_d;

    logic        rst2_n, stall2, redir2;
    logic [31:0] target2;
    logic        valid2;
    logic [31:0] instr2, pc2, pcp42;
    logic [5:0]  op2, funct2;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall_d(stall_d),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem(bus), .valid_d(valid_d), .instr_d(instr_d), .op_d(op_d),
        .funct_d(funct_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d)
    );

    fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst2_n), .stall_d(stall2),
        .redirect_valid(redir2), .redirect_target(target2),
        .imem(bus2), .valid_d(valid2), .instr_d(instr2), .op_d(op2),
        .funct_d(funct2), .pc_d(pc2), .pcplus4_d(pcp42)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    typedef struct {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic st, input logic rdr, input logic [31:0] tg,
                                input logic eq, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.ready = rdy; v.rvalid = rv; v.rdata = rd; v.stall = st; v.redir = rdr;
        v.target = tg; v.e_req = eq; v.e_addr = ea; v.e_valid = ev;
        v.e_instr = ei; v.e_pc = ep;
        return v;
    endfunction

    vec_t vt[22];

    // random-phase model state
    logic [31:0] exp_pc;
    logic        prev_stall, prev_redir;
    logic [31:0] prev_target;
    logic        snap_valid;
    logic [31:0] snap_instr, snap_pc, snap_pcp4;
    logic        pend;
    logic [31:0] paddr;
    int          pcnt;
    int          ndeliv;
    logic        seen_accept;
    logic [31:0] acc_q[$];
    logic        first2;

    initial begin
        // ready rv rdata st rd target | req addr valid instr pc
        vt[0]  = mk(1, 0, 32'h0,         0, 0, 32'h0,   0, 32'h000, 0, 32'h0,         32'h0);
        vt[1]  = mk(1, 0, 32'h0,         0, 0, 32'h0,   1, 32'h000, 0, 32'h0,         32'h0);
        vt[2]  = mk(0, 1, 32'h8C010004,  0, 0, 32'h0,   0, 32'h000, 0, 32'h0,         32'h0);
        vt[3]  = mk(1, 0, 32'h0,         0, 0, 32'h0,   1, 32'h004, 1, 32'h8C010004,  32'h0);
        vt[4]  = mk(0, 1, 32'h3421000F,  0, 0, 32'h0,   0, 32'h004, 0, 32'h0,         32'h0);
        vt[5]  = mk(1, 0, 32'h0,         0, 0, 32'h0,   1, 32'h008, 1, 32'h3421000F,  32'h4);
        vt[6]  = mk(0, 1, 32'h00221820,  1, 0, 32'h0,   0, 32'h008, 0, 32'h0,         32'h0);
        vt[7]  = mk(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h008, 0, 32'h0,         32'h0);
        vt[8]  = mk(1, 0, 32'h0,         1, 0, 32'h0,   0, 32'h008, 0, 32'h0,         32'h0);
        vt[9]  = mk(1, 0, 32'h0,         1, 0, 32'h0,   0, 32'h008, 0, 32'h0,         32'h0);
        vt[10] = mk(1, 0, 32'h0,         1, 0, 32'h0,   0, 32'h008, 0, 32'h0,         32'h0);
        vt[11] = mk(0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h008, 0, 32'h0,         32'h0);
        vt[12] = mk(1, 0, 32'h0,         0, 0, 32'h0,   1, 32'h00C, 1, 32'h00221820,  32'h8);
        vt[13] = mk(0, 0, 32'h0,         0, 1, 32'h43,  0, 32'h00C, 0, 32'h0,         32'h0);
        vt[14] = mk(0, 1, 32'hDEADBEEF,  0, 0, 32'h0,   0, 32'h040, 0, 32'h0,         32'h0);
        vt[15] = mk(1, 0, 32'h0,         0, 0, 32'h0,   1, 32'h040, 0, 32'h0,         32'h0);
        vt[16] = mk(0, 1, 32'h11111111,  0, 0, 32'h0,   0, 32'h040, 0, 32'h0,         32'h0);
        vt[17] = mk(1, 0, 32'h0,         1, 1, 32'h100, 1, 32'h044, 1, 32'h11111111,  32'h40);
        vt[18] = mk(0, 1, 32'h0BADBAD0,  0, 0, 32'h0,   0, 32'h100, 0, 32'h0,         32'h0);
        vt[19] = mk(1, 0, 32'h0,         0, 0, 32'h0,   1, 32'h100, 0, 32'h0,         32'h0);
        vt[20] = mk(0, 1, 32'h22222222,  0, 0, 32'h0,   0, 32'h100, 0, 32'h0,         32'h0);
        vt[21] = mk(0, 0, 32'h0,         0, 0, 32'h0,   1, 32'h104, 1, 32'h22222222,  32'h100);

        rst_n = 1'b0; stall_d = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        rst2_n = 1'b0; stall2 = 1'b0; redir2 = 1'b0; target2 = '0;
        bus2.imem_ready = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;

        repeat (3) @(negedge clk);
        chk("reset_req", {31'b0, bus.imem_req}, 32'h0);
        chk("reset_addr", bus.imem_addr, 32'h0);
        chk("reset_valid", {31'b0, valid_d}, 32'h0);
        rst_n = 1'b1;

        // directed table: check state, then drive inputs for the coming edge
        for (int unsigned i = 0; i < 22; i++) begin
            chk($sformatf("vec%0d_req", i), {31'b0, bus.imem_req}, {31'b0, vt[i].e_req});
            chk($sformatf("vec%0d_addr", i), bus.imem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, valid_d}, {31'b0, vt[i].e_valid});
            chk($sformatf("vec%0d_instr", i), instr_d, vt[i].e_instr);
            chk($sformatf("vec%0d_op", i), {26'b0, op_d}, {26'b0, vt[i].e_instr[31:26]});
            chk($sformatf("vec%0d_funct", i), {26'b0, funct_d}, {26'b0, vt[i].e_instr[5:0]});
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), pc_d, vt[i].e_pc);
                chk($sformatf("vec%0d_pcp4", i), pcplus4_d, vt[i].e_pc + 32'd4);
            end
            bus.imem_ready  = vt[i].ready;
            bus.imem_rvalid = vt[i].rvalid;
            bus.imem_rdata  = vt[i].rdata;
            stall_d         = vt[i].stall;
            redirect_valid  = vt[i].redir;
            redirect_target = vt[i].target;
            @(negedge clk);
        end

        // reset asserted while a fetch is in flight
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0;
        stall_d = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk("midfetch_in_wait", {31'b0, bus.imem_req}, 32'h0);
        bus.imem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", {31'b0, bus.imem_req}, 32'h0);
        chk("async_addr", bus.imem_addr, 32'h0);
        chk("async_valid", {31'b0, valid_d}, 32'h0);
        chk("async_instr", instr_d, 32'h0);
        chk("async_pc", pc_d, 32'h0);
        chk("async_pcp4", pcplus4_d, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized run: delivered instructions must follow program order from
        // PC_RESET, restarting at each redirect target
        exp_pc = 32'h0; prev_stall = 1'b0; prev_redir = 1'b0; prev_target = '0;
        pend = 1'b0; paddr = '0; pcnt = 0; ndeliv = 0; seen_accept = 1'b0;
        for (int unsigned c = 0; c < 3000; c++) begin
            if (prev_redir) begin
                chk("rnd_flush_valid", {31'b0, valid_d}, 32'h0);
                chk("rnd_flush_instr", instr_d, 32'h0);
                exp_pc = {prev_target[31:2], 2'b00};
            end else if (prev_stall) begin
                chk("rnd_hold_valid", {31'b0, valid_d}, {31'b0, snap_valid});
                chk("rnd_hold_instr", instr_d, snap_instr);
                chk("rnd_hold_pc", pc_d, snap_pc);
                chk("rnd_hold_pcp4", pcplus4_d, snap_pcp4);
            end else if (valid_d) begin
                chk("rnd_pc", pc_d, exp_pc);
                chk("rnd_instr", instr_d, mem_word(exp_pc));
                chk("rnd_pcp4", pcplus4_d, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                ndeliv++;
            end else begin
                chk("rnd_bubble_instr", instr_d, 32'h0);
            end
            chk("rnd_op", {26'b0, op_d}, {26'b0, instr_d[31:26]});
            chk("rnd_funct", {26'b0, funct_d}, {26'b0, instr_d[5:0]});
            chk("rnd_align", {30'b0, bus.imem_addr[1:0]}, 32'h0);

            snap_valid = valid_d; snap_instr = instr_d; snap_pc = pc_d; snap_pcp4 = pcplus4_d;

            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            if (pend) begin
                if (pcnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(paddr);
                    pend = 1'b0;
                end else begin
                    pcnt--;
                end
            end
            bus.imem_ready  = ($urandom_range(0, 3) != 0);
            stall_d         = ($urandom_range(0, 4) == 0);
            redirect_valid  = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom;
            if (bus.imem_req && bus.imem_ready) begin
                if (!seen_accept) begin
                    chk("refetch_at_reset_pc", bus.imem_addr, 32'h0);
                    seen_accept = 1'b1;
                end
                pend  = 1'b1;
                paddr = bus.imem_addr;
                pcnt  = $urandom_range(0, 2);
            end
            prev_stall = stall_d; prev_redir = redirect_valid; prev_target = redirect_target;
            @(negedge clk);
        end
        chk("rnd_progress", {31'b0, (ndeliv >= 150)}, 32'h1);
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; stall_d = 1'b0; redirect_valid = 1'b0;

        // PC wrap on an instance reset to the top word
        rst2_n = 1'b1;
        pend = 1'b0; first2 = 1'b0;
        for (int unsigned c = 0; c < 12; c++) begin
            if (valid2 && !first2) begin
                chk("wrap_pc", pc2, 32'hFFFF_FFFC);
                chk("wrap_pcp4", pcp42, 32'h0000_0000);
                chk("wrap_instr", instr2, mem_word(32'hFFFF_FFFC));
                first2 = 1'b1;
            end
            bus2.imem_rvalid = pend;
            bus2.imem_rdata  = mem_word(paddr);
            pend = 1'b0;
            bus2.imem_ready = 1'b1;
            if (bus2.imem_req) begin
                acc_q.push_back(bus2.imem_addr);
                pend  = 1'b1;
                paddr = bus2.imem_addr;
            end
            @(negedge clk);
        end
        chk("wrap_delivered", {31'b0, first2}, 32'h1);
        if (acc_q.size() >= 2) begin
            chk("wrap_addr0", acc_q[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", acc_q[1], 32'h0000_0000);
        end else begin
            chk("wrap_accepts", acc_q.size(), 32'd2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
